// File: rtl/data_mem_responder.sv
// Data-memory responder: serves single-word loads and stores from a small register array
// after a fixed access latency, stalling the core meanwhile and pulsing ready on completion.
module data_mem_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              stall,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state;
    logic [3:0]        count;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic              finish;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_rd;
    logic              acc_wr;

    assign req   = mem_read | mem_write;
    assign stall = ((state == IDLE) && req) || (state == BUSY);

    // With LATENCY==1 the access completes on the acceptance edge itself, so the
    // live request is used; otherwise the values latched at acceptance are used.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_rd    = rd_q;
        acc_wr    = wr_q;
        finish    = 1'b0;
        if (state == IDLE) begin
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_rd    = mem_read;
            acc_wr    = mem_write;
            finish    = req && (LATENCY == 1);
        end else if (state == BUSY) begin
            finish = (count == 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            // NOTE: the array is flops, not a RAM macro, because it must read back zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ready <= 1'b0;
            err   <= 1'b0;
            if (finish) begin
                ready <= 1'b1;
                if (acc_rd && acc_wr) begin
                    err <= 1'b1;
                end else if (acc_wr) begin
                    mem[acc_addr] <= acc_wdata;
                end else begin
                    rdata <= mem[acc_addr];
                end
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        rd_q    <= mem_read;
                        wr_q    <= mem_write;
                        count   <= CNT_INIT;
                        state   <= (LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three builds (LATENCY 2, 1, 15) share clock and reset;
// each access pushes its predicted result and pops it when ready is observed.
module tb_data_mem_responder;

    typedef struct {
        int         k;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [2:0]       mem_read_v;
    logic [2:0]       mem_write_v;
    logic [2:0][3:0]  addr_v;
    logic [2:0][7:0]  wdata_v;
    logic [2:0][7:0]  rdata_v;
    logic [2:0]       ready_v;
    logic [2:0]       stall_v;
    logic [2:0]       err_v;

    int         n_checks;
    int         n_fail;
    exp_t       sb[$];
    logic [7:0] model_mem [3][16];
    logic [7:0] model_rdata [3];
    int         lat [3] = '{2, 1, 15};

    data_mem_responder #(.DATA_W(8), .ADDR_W(4), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read_v[0]), .mem_write(mem_write_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]),
        .rdata(rdata_v[0]), .ready(ready_v[0]), .stall(stall_v[0]), .err(err_v[0])
    );

    data_mem_responder #(.DATA_W(8), .ADDR_W(4), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read_v[1]), .mem_write(mem_write_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]),
        .rdata(rdata_v[1]), .ready(ready_v[1]), .stall(stall_v[1]), .err(err_v[1])
    );

    data_mem_responder #(.DATA_W(8), .ADDR_W(4), .LATENCY(15)) dut_l15 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read_v[2]), .mem_write(mem_write_v[2]),
        .addr(addr_v[2]), .wdata(wdata_v[2]),
        .rdata(rdata_v[2]), .ready(ready_v[2]), .stall(stall_v[2]), .err(err_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            model_rdata[k] = 8'h00;
            for (int a = 0; a < 16; a++) model_mem[k][a] = 8'h00;
        end
    endtask

    // One access on build k; corrupt keeps the request high and scrambles addr/wdata after acceptance.
    task automatic access(input int k, input logic rd, input logic wr, input logic [3:0] a,
                          input logic [7:0] d, input logic corrupt);
        exp_t e;
        exp_t g;
        int   stalls;
        bit   done;
        e.k   = k;
        e.err = rd & wr;
        if (!(rd && wr)) begin
            if (wr) model_mem[k][a] = d;
            else    model_rdata[k] = model_mem[k][a];
        end
        e.rdata = model_rdata[k];
        sb.push_back(e);

        @(negedge clk);
        mem_read_v[k]  = rd;
        mem_write_v[k] = wr;
        addr_v[k]      = a;
        wdata_v[k]     = d;
        stalls = 0;
        done   = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (ready_v[k]) begin
                done = 1;
                mem_read_v[k]  = 1'b0;
                mem_write_v[k] = 1'b0;
                g = sb.pop_front();
                n_checks++;
                if (rdata_v[k] !== g.rdata) begin
                    n_fail++;
                    $display("FAIL rdata dut%0d addr=%0d: got %h expected %h", k, a, rdata_v[k], g.rdata);
                end
                n_checks++;
                if (err_v[k] !== g.err) begin
                    n_fail++;
                    $display("FAIL err dut%0d addr=%0d: got %b expected %b", k, a, err_v[k], g.err);
                end
                n_checks++;
                if (stall_v[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_done dut%0d: got %b expected 0", k, stall_v[k]);
                end
            end else begin
                if (stall_v[k]) stalls++;
                @(posedge clk);
                #1;
                if (corrupt) begin
                    addr_v[k]  = ~a;
                    wdata_v[k] = ~d;
                end else begin
                    mem_read_v[k]  = 1'b0;
                    mem_write_v[k] = 1'b0;
                end
                @(negedge clk);
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL ready_timeout dut%0d: got no ready expected ready within 40 cycles", k);
            mem_read_v[k]  = 1'b0;
            mem_write_v[k] = 1'b0;
            void'(sb.pop_front());
        end else begin
            n_checks++;
            if (stalls !== lat[k]) begin
                n_fail++;
                $display("FAIL stall_cycles dut%0d: got %0d expected %0d", k, stalls, lat[k]);
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (ready_v[k] !== 1'b0 || err_v[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL pulse_width dut%0d: got ready=%b err=%b expected 0 0", k, ready_v[k], err_v[k]);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdata_v[k] !== 8'h00 || ready_v[k] !== 1'b0 || err_v[k] !== 1'b0 || stall_v[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d: got rdata=%h ready=%b err=%b stall=%b expected all 0",
                         tag, k, rdata_v[k], ready_v[k], err_v[k], stall_v[k]);
            end
        end
    endtask

    task automatic test_reset();
        mem_read_v  = '0;
        mem_write_v = '0;
        addr_v      = '0;
        wdata_v     = '0;
        rst_n       = 1'b0;
        clear_model();
        #3;
        check_outputs_zero("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_load();
        access(0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        access(0, 1'b0, 1'b1, 4'd7, 8'hA5, 1'b0);
        access(0, 1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    endtask

    task automatic test_mid_busy_change();
        access(0, 1'b0, 1'b1, 4'd2, 8'h3C, 1'b1);
        access(0, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
        access(0, 1'b1, 1'b0, 4'd13, 8'h00, 1'b0);
    endtask

    task automatic test_conflict();
        access(0, 1'b0, 1'b1, 4'd5, 8'h11, 1'b0);
        access(0, 1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
        access(0, 1'b1, 1'b1, 4'd5, 8'hEE, 1'b0);
        access(0, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid_busy();
        access(0, 1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
        @(negedge clk);
        mem_write_v[0] = 1'b1;
        addr_v[0]      = 4'd1;
        wdata_v[0]     = 8'hFF;
        @(posedge clk);
        #1;
        mem_write_v[0] = 1'b0;
        #2;
        n_checks++;
        if (stall_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_before_reset: got stall=%b expected 1", stall_v[0]);
        end
        rst_n = 1'b0;
        clear_model();
        #1;
        check_outputs_zero("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0);
        access(0, 1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    endtask

    task automatic test_latency_builds();
        access(1, 1'b1, 1'b0, 4'd4, 8'h00, 1'b0);
        access(1, 1'b0, 1'b1, 4'd4, 8'h5A, 1'b0);
        access(1, 1'b1, 1'b0, 4'd4, 8'h00, 1'b0);
        access(2, 1'b0, 1'b1, 4'd15, 8'hC3, 1'b0);
        access(2, 1'b1, 1'b0, 4'd15, 8'h00, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_first_load();
        test_back_to_back();
        test_mid_busy_change();
        test_conflict();
        test_reset_mid_busy();
        test_latency_builds();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
